alu_exec_unit: RTL and testbench

- Execute stage of the multicycle datapath, directly downstream of the ALU operand-B select mux.
- Combines operand A (A register output) with the selected operand B (ALU2Out) and produces a combinational result and flags.
- Holds the registered ALUOut.
- Contains a sequential signed multiply/divide engine that writes the HI/LO registers under a start/busy/done handshake.

---
 rtl/alu_exec_unit_pkg.sv | 15 +
 rtl/alu_exec_unit_mult_div_engine.sv | 98 +++++++++
 rtl/alu_exec_unit.sv | 75 +++++++
 tb/tb_alu_exec_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
// alu_exec_unit_pkg: shared ALU opcodes, mult/div FSM states and default width
package alu_exec_unit_pkg;
    localparam int WIDTH_DEF = 32;
    typedef enum logic [2:0] {
        ALU_PASSA = 3'b000,
        ALU_ADD   = 3'b001,
        ALU_SUB   = 3'b010,
        ALU_AND   = 3'b011,
        ALU_OR    = 3'b100,
        ALU_XOR   = 3'b101,
        ALU_NOTA  = 3'b110,
        ALU_SLT   = 3'b111
    } alu_op_e;
    typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_e;
endpackage

// File: rtl/alu_exec_unit_mult_div_engine.sv
// mult_div_engine: iterative signed Booth multiply / restoring divide writing HI and LO
module mult_div_engine
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int MD_CYCLES = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    input  logic             div,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    localparam int CW = $clog2(MD_CYCLES + 1);
    md_state_e        state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   acc, m, booth, r_sh, diff, acc_n;
    logic [WIDTH-1:0] q, q_n, a_mag, b_mag, hi_n, lo_n;
    logic             qm1, is_div, neg_q, neg_r, ok;
    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;
    // acc is one bit wider so Booth add/sub of the most negative multiplicand cannot overflow
    assign booth = (q[0] & ~qm1) ? acc - m : (~q[0] & qm1) ? acc + m : acc;
    assign r_sh  = {acc[WIDTH-1:0], q[WIDTH-1]};
    assign diff  = r_sh - m;
    assign ok    = ~diff[WIDTH];
    assign acc_n = is_div ? (ok ? diff : r_sh) : {booth[WIDTH], booth[WIDTH:1]};
    assign q_n   = is_div ? {q[WIDTH-2:0], ok} : {booth[0], q[WIDTH-1:1]};
    assign hi_n  = is_div ? (neg_r ? -acc_n[WIDTH-1:0] : acc_n[WIDTH-1:0]) : acc_n[WIDTH-1:0];
    assign lo_n  = is_div ? (neg_q ? -q_n : q_n) : q_n;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= MD_IDLE;
            cnt      <= '0;
            acc      <= '0;
            m        <= '0;
            q        <= '0;
            qm1      <= 1'b0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        div_zero <= 1'b0;
                        is_div   <= div;
                        acc      <= '0;
                        qm1      <= 1'b0;
                        cnt      <= '0;
                        neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
                        neg_r    <= a[WIDTH-1];
                        q        <= div ? a_mag : a;
                        m        <= div ? {1'b0, b_mag} : {b[WIDTH-1], b};
                        if (div && b == '0) begin
                            div_zero <= 1'b1;
                            done     <= 1'b1;
                            state    <= MD_DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= MD_RUN;
                        end
                    end
                end
                MD_RUN: begin
                    acc <= acc_n;
                    q   <= q_n;
                    qm1 <= q[0];
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(MD_CYCLES - 1)) begin
                        hi    <= hi_n;
                        lo    <= lo_n;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    done  <= 1'b0;
                    state <= MD_IDLE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage ALU with flags, registered ALUOut and HI/LO mult/div engine
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int MD_CYCLES = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] AOut,
    input  logic [WIDTH-1:0] ALU2Out,
    input  logic [2:0]       ALUop,
    input  logic             ALUOut_load,
    input  logic             md_start,
    input  logic             md_div,
    output logic [WIDTH-1:0] ALUResult,
    output logic [WIDTH-1:0] ALUOut,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    alu_op_e          op;
    logic [WIDTH-1:0] sum, dif;
    assign op  = alu_op_e'(ALUop);
    assign sum = AOut + ALU2Out;
    assign dif = AOut - ALU2Out;
    assign eq  = AOut == ALU2Out;
    assign lt  = $signed(AOut) < $signed(ALU2Out);
    assign gt  = $signed(AOut) > $signed(ALU2Out);
    always_comb begin
        ALUResult = AOut;
        case (op)
            ALU_PASSA: ALUResult = AOut;
            ALU_ADD:   ALUResult = sum;
            ALU_SUB:   ALUResult = dif;
            ALU_AND:   ALUResult = AOut & ALU2Out;
            ALU_OR:    ALUResult = AOut | ALU2Out;
            ALU_XOR:   ALUResult = AOut ^ ALU2Out;
            ALU_NOTA:  ALUResult = ~AOut;
            ALU_SLT:   ALUResult = {{(WIDTH-1){1'b0}}, lt};
            default:   ALUResult = AOut;
        endcase
    end
    // signed overflow: result sign disagrees with A when the effective operands share a sign
    assign ovf  = op == ALU_ADD ? (AOut[WIDTH-1] == ALU2Out[WIDTH-1]) && (sum[WIDTH-1] != AOut[WIDTH-1])
                : op == ALU_SUB ? (AOut[WIDTH-1] != ALU2Out[WIDTH-1]) && (dif[WIDTH-1] != AOut[WIDTH-1])
                : 1'b0;
    assign zero = ALUResult == '0;
    assign neg  = ALUResult[WIDTH-1];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ALUOut <= '0;
        else if (ALUOut_load) ALUOut <= ALUResult;
    end
    mult_div_engine #(.WIDTH(WIDTH), .MD_CYCLES(MD_CYCLES)) u_md (
        .clk      (clk),
        .reset    (reset),
        .a        (AOut),
        .b        (ALU2Out),
        .start    (md_start),
        .div      (md_div),
        .hi       (HI),
        .lo       (LO),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors checked against a behavioural model every cycle
module tb_alu_exec_unit;
    localparam int W = 32;
    logic          clk = 1'b0, reset = 1'b1;
    logic [W-1:0]  AOut = '0, ALU2Out = '0;
    logic [2:0]    ALUop = '0;
    logic          ALUOut_load = 1'b0, md_start = 1'b0, md_div = 1'b0;
    logic [W-1:0]  ALUResult, ALUOut, HI, LO;
    logic          zero, neg, ovf, eq, gt, lt, busy, done, div_zero;
    int            checks = 0, errors = 0;
    logic [W-1:0]  m_aluout, m_hi, m_lo, p_hi, p_lo;
    logic          m_busy, m_done, m_dz;
    int            m_cnt;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(W), .MD_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .AOut(AOut), .ALU2Out(ALU2Out), .ALUop(ALUop),
        .ALUOut_load(ALUOut_load), .md_start(md_start), .md_div(md_div),
        .ALUResult(ALUResult), .ALUOut(ALUOut), .zero(zero), .neg(neg), .ovf(ovf),
        .eq(eq), .gt(gt), .lt(lt), .HI(HI), .LO(LO), .busy(busy), .done(done),
        .div_zero(div_zero)
    );

    function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0: return a;
            3'd1: return a + b;
            3'd2: return a - b;
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: return a ^ b;
            3'd6: return ~a;
            default: return (sa < sb) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // {zero, neg, ovf, eq, gt, lt}
    function automatic logic [5:0] flags_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        int sa, sb;
        longint r;
        logic [W-1:0] res;
        sa = a;
        sb = b;
        res = alu_ref(a, b, op);
        r = op == 3'd1 ? longint'(sa) + longint'(sb) : longint'(sa) - longint'(sb);
        return {res == 0, res[W-1], (op == 3'd1 || op == 3'd2) && (r > 64'sd2147483647 || r < -64'sd2147483648),
                sa == sb, sa > sb, sa < sb};
    endfunction

    function automatic logic [63:0] md_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic div);
        int sa, sb;
        longint p, qq, rr;
        sa = a;
        sb = b;
        p  = longint'(sa) * longint'(sb);
        if (!div) return p;
        qq = longint'(sa) / longint'(sb);
        rr = longint'(sa) % longint'(sb);
        return {rr[31:0], qq[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_aluout <= '0; m_hi <= '0; m_lo <= '0; p_hi <= '0; p_lo <= '0;
            m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0; m_cnt <= 0;
        end else begin
            if (ALUOut_load) m_aluout <= alu_ref(AOut, ALU2Out, ALUop);
            if (m_done) m_done <= 1'b0;
            else if (m_busy) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_busy <= 1'b0; m_done <= 1'b1; m_hi <= p_hi; m_lo <= p_lo;
                end
            end else if (md_start) begin
                if (md_div && ALU2Out == 0) begin
                    m_dz <= 1'b1; m_done <= 1'b1;
                end else begin
                    m_dz <= 1'b0; m_busy <= 1'b1; m_cnt <= W;
                    {p_hi, p_lo} <= md_ref(AOut, ALU2Out, md_div);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("cyc_result", ALUResult, alu_ref(AOut, ALU2Out, ALUop));
            check("cyc_flags", {zero, neg, ovf, eq, gt, lt}, flags_ref(AOut, ALU2Out, ALUop));
            check("cyc_aluout", ALUOut, m_aluout);
            check("cyc_busy_done_dz", {busy, done, div_zero}, {m_busy, m_done, m_dz});
            check("cyc_hilo", {HI, LO}, {m_hi, m_lo});
        end
    end

    task automatic alu_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                           input logic [W-1:0] exp_r, input logic [5:0] exp_f);
        AOut = a; ALU2Out = b; ALUop = op;
        #2;
        check({name, "_res"}, ALUResult, exp_r);
        check({name, "_flags"}, {zero, neg, ovf, eq, gt, lt}, exp_f);
        @(posedge clk); #1;
    endtask

    task automatic md_run(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic div,
                          input bit poke, input int exp_n, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int n;
        AOut = a; ALU2Out = b; md_div = div; md_start = 1'b1;
        @(posedge clk); #1;
        md_start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            md_start = poke && n == 5;
            if (md_start) begin AOut = 9; ALU2Out = 3; md_div = ~div; end
            @(posedge clk); #1;
            n++;
        end
        md_start = 1'b0;
        check({name, "_latency"}, n, exp_n);
        check({name, "_hi"}, HI, exp_hi);
        check({name, "_lo"}, LO, exp_lo);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_regs", {ALUOut, HI, LO}, '0);
        check("rst_ctl", {busy, done, div_zero}, 3'b000);
        alu_vec("add_ovf", 32'h7FFFFFFF, 32'h1, 3'b001, 32'h80000000, 6'b011010);
        ALUOut_load = 1'b1;
        @(posedge clk); #1;
        ALUOut_load = 1'b0;
        check("aluout_load", ALUOut, 32'h80000000);
        alu_vec("sub_zero", 32'd5, 32'd5, 3'b010, 32'h0, 6'b100100);
        alu_vec("slt", 32'hFFFFFFFF, 32'h1, 3'b111, 32'h1, 6'b000001);
        alu_vec("sub_ovf", 32'h80000000, 32'h1, 3'b010, 32'h7FFFFFFF, 6'b001001);
        alu_vec("not_a", 32'h0, 32'h0, 3'b110, 32'hFFFFFFFF, 6'b010101 & 6'b010100);
        alu_vec("xor", 32'hF0F0F0F0, 32'h0FF00FF0, 3'b101, 32'hFF00FF00, 6'b010001);
        md_run("mul_neg", 32'hFFFFFFFD, 32'd7, 1'b0, 1'b1, 32, 32'hFFFFFFFF, 32'hFFFFFFEB);
        md_run("div_neg", 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 32, 32'hFFFFFFFF, 32'hFFFFFFFD);
        md_run("div_min", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32, 32'h0, 32'h80000000);
        check("div_min_dz", div_zero, 1'b0);
        md_run("mul_min", 32'h80000000, 32'h80000000, 1'b0, 1'b0, 32, 32'h40000000, 32'h0);
        md_run("div_pos_neg", 32'd7, 32'hFFFFFFFE, 1'b1, 1'b0, 32, 32'h1, 32'hFFFFFFFD);
        md_run("div_zero", 32'd5, 32'd0, 1'b1, 1'b0, 0, 32'h1, 32'hFFFFFFFD);
        check("div_zero_flag", div_zero, 1'b1);
        md_run("div_after_dz", 32'd100, 32'd7, 1'b1, 1'b0, 32, 32'h2, 32'hE);
        check("dz_cleared", div_zero, 1'b0);
        AOut = 32'd1; ALU2Out = 32'd1; ALUop = 3'b001; ALUOut_load = 1'b1;
        @(posedge clk); #1;
        ALUOut_load = 1'b0;
        check("aluout_pre_rst", ALUOut, 32'd2);
        AOut = 32'd3; ALU2Out = 32'd5; md_div = 1'b0; md_start = 1'b1;
        @(posedge clk); #1;
        md_start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("busy_pre_rst", busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_regs", {ALUOut, HI, LO}, '0);
        check("rst_mid_ctl", {busy, done, div_zero}, 3'b000);
        @(posedge clk); #1 reset = 1'b0;
        #1;
        check("rst_idle", {busy, done}, 2'b00);
        md_run("mul_after_rst", 32'd3, 32'd5, 1'b0, 1'b0, 32, 32'h0, 32'd15);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
